// File: rtl/mux4way_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4way_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one 32-bit 4:1 datapath mux among four
//   valid/ready requesters (ALU, load unit, PC logic, immediate path) feeding a
//   single shared write-back consumer. The grant and the mux select are
//   registered; the granted requester keeps the datapath for up to MAX_BURST
//   accepted transfers, or until it withdraws its valid. Every release passes
//   through IDLE, so there is always a one-cycle bubble between grants.
//
// Parameters:
//   MAX_BURST  accepted transfers per grant before forced rotation (1..15)
//   CNT_W      width of each statistics counter (MUX_ARB_STATS_EN only)
//
// Optional feature macro:
//   MUX_ARB_STATS_EN  adds stat_clr / stat_cnt and one saturating
//                     accepted-transfer counter per requester.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  per-requester valid, bit i = requester i
//   req_data0..req_data3  per-requester data words
//   req_ready  per-requester ready, only the granted bit can be high
//   out_valid  consumer-side valid
//   out_ready  consumer-side ready
//   out_data   data word of the granted requester
//   sel        registered mux select (granted index)
//   gnt        registered one-hot grant, zero when idle
//   stat_clr   clear all statistics counters (MUX_ARB_STATS_EN only)
//   stat_cnt   per-requester transfer counts, requester 0 in the LSBs
//              (MUX_ARB_STATS_EN only)
//
// Sub-module:
//   mux4way32bit  plain combinational 32-bit 4:1 mux
// -----------------------------------------------------------------------------

// 32-bit 4:1 multiplexer used as the shared datapath.
module mux4way32bit (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [1:0]  sel,
    output logic [31:0] out
);

    // Select one of four data words.
    always_comb begin
        out = 32'd0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = 32'd0;
        endcase
    end

endmodule

module mux4way_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_valid,
    input  logic [31:0]          req_data0,
    input  logic [31:0]          req_data1,
    input  logic [31:0]          req_data2,
    input  logic [31:0]          req_data3,
    output logic [3:0]           req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [1:0]           sel,
    output logic [3:0]           gnt
`ifdef MUX_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [4*CNT_W-1:0]   stat_cnt
`endif
);

    // Reject illegal configurations at elaboration time.
    if (MAX_BURST < 1 || MAX_BURST > 15 || CNT_W < 1) begin : g_param_check
        $error("mux4way_rr_arbiter: MAX_BURST must be 1..15 and CNT_W >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Beat index of the final transfer of a grant.
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state_r;
    logic [1:0]  ptr_r;
    logic [3:0]  beat_r;
    logic [1:0]  sel_r;
    logic [3:0]  gnt_r;

    logic        grant_valid_s;
    logic [3:0]  ready_s;
    logic        xfer_s;
    logic [1:0]  pick_s;
    logic [31:0] mux_out_s;

    // First valid requester searching ptr, ptr+1, ... (mod 4). Iterating from
    // the farthest offset down lets the nearest match overwrite the result.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Winner of the next arbitration round.
    always_comb begin
        pick_s = rr_pick(req_valid, ptr_r);
    end

    // Handshake outputs: only meaningful while a grant is held.
    always_comb begin
        grant_valid_s = 1'b0;
        ready_s       = 4'b0000;
        if (state_r == ST_GRANT) begin
            grant_valid_s = req_valid[sel_r];
            ready_s       = gnt_r & {4{out_ready}};
        end else begin
            grant_valid_s = 1'b0;
            ready_s       = 4'b0000;
        end
    end

    assign xfer_s = grant_valid_s & out_ready;

    // Arbitration FSM: grant, burst counting, release and rotation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            beat_r  <= 4'd0;
            sel_r   <= 2'd0;
            gnt_r   <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid != 4'b0000) begin
                        sel_r   <= pick_s;
                        gnt_r   <= 4'b0001 << pick_s;
                        beat_r  <= 4'd0;
                        state_r <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (xfer_s) begin
                        if (beat_r == LAST_BEAT) begin
                            // Burst exhausted: rotate priority past this requester.
                            state_r <= ST_IDLE;
                            ptr_r   <= sel_r + 2'd1;
                            gnt_r   <= 4'b0000;
                        end else begin
                            beat_r  <= beat_r + 4'd1;
                        end
                    end else if (!req_valid[sel_r]) begin
                        // Requester withdrew; this also wins over a
                        // simultaneous out_ready since no transfer occurred.
                        state_r <= ST_IDLE;
                        ptr_r   <= sel_r + 2'd1;
                        gnt_r   <= 4'b0000;
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 4'b0000;
                end
            endcase
        end
    end

    mux4way32bit u_mux (
        .in0 (req_data0),
        .in1 (req_data1),
        .in2 (req_data2),
        .in3 (req_data3),
        .sel (sel_r),
        .out (mux_out_s)
    );

    assign sel       = sel_r;
    assign gnt       = gnt_r;
    assign out_valid = grant_valid_s;
    assign req_ready = ready_s;
    assign out_data  = mux_out_s;

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_r [4];

    // Saturating per-requester transfer counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (xfer_s && (sel_r == 2'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Pack the counters onto the flat statistics bus.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            stat_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_mux4way_rr_arbiter.sv
// Directed testbench for mux4way_rr_arbiter. Instance A uses MAX_BURST=4,
// instance B uses MAX_BURST=1; with MUX_ARB_STATS_EN an extra instance C
// (CNT_W=2) exercises the saturating counters.
module tb_mux4way_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] d0, d1, d2, d3;
    logic [31:0] dat [4];

    logic [3:0]  va, vb;
    logic        ora, ob;
    logic [3:0]  rdy_a, rdy_b, gnt_a, gnt_b;
    logic        ov_a, ov_b;
    logic [31:0] od_a, od_b;
    logic [1:0]  sel_a, sel_b;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX_ARB_STATS_EN
    logic        clr0;
    logic [63:0] cnt_a, cnt_b;
    logic [3:0]  vc, rdy_c, gnt_c;
    logic        oc, clrc, ov_c;
    logic [31:0] od_c;
    logic [1:0]  sel_c;
    logic [7:0]  cnt_c;
`endif

    mux4way_rr_arbiter #(.MAX_BURST(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(rdy_a), .out_valid(ov_a), .out_ready(ora), .out_data(od_a),
        .sel(sel_a), .gnt(gnt_a)
`ifdef MUX_ARB_STATS_EN
        , .stat_clr(clr0), .stat_cnt(cnt_a)
`endif
    );

    mux4way_rr_arbiter #(.MAX_BURST(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(rdy_b), .out_valid(ov_b), .out_ready(ob), .out_data(od_b),
        .sel(sel_b), .gnt(gnt_b)
`ifdef MUX_ARB_STATS_EN
        , .stat_clr(clr0), .stat_cnt(cnt_b)
`endif
    );

`ifdef MUX_ARB_STATS_EN
    mux4way_rr_arbiter #(.MAX_BURST(15), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(vc),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(rdy_c), .out_valid(ov_c), .out_ready(oc), .out_data(od_c),
        .sel(sel_c), .gnt(gnt_c), .stat_clr(clrc), .stat_cnt(cnt_c)
    );
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        d0 = 32'hA000_0000; d1 = 32'hB111_1111; d2 = 32'hC222_2222; d3 = 32'hD333_3333;
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
        rst_n = 1'b0; va = 4'b0000; ora = 1'b0; vb = 4'b0000; ob = 1'b0;
`ifdef MUX_ARB_STATS_EN
        clr0 = 1'b0; vc = 4'b0000; oc = 1'b0; clrc = 1'b0;
`endif
        tick(); tick(); #1;
        check("rst_gnt", gnt_a, 32'h0);
        check("rst_sel", sel_a, 32'h0);
        check("rst_ov", ov_a, 32'h0);
        check("rst_rdy", rdy_a, 32'h0);
        check("rst_gnt_b", gnt_b, 32'h0);
        rst_n = 1'b1;

        // Single requester 2, full burst of four transfers.
        va = 4'b0100; ora = 1'b1; #1;
        check("t1_idle_ov", ov_a, 32'h0);
        tick(); #1;
        check("t1_gnt", gnt_a, 32'h4);
        check("t1_sel", sel_a, 32'h2);
        check("t1_ov", ov_a, 32'h1);
        check("t1_data", od_a, d2);
        check("t1_rdy", rdy_a, 32'h4);
        tick(); tick(); tick(); #1;
        check("t1_last_beat_gnt", gnt_a, 32'h4);
        tick();
        va = 4'b1111; #1;
        check("t1_release_gnt", gnt_a, 32'h0);
        check("t1_release_ov", ov_a, 32'h0);
        tick(); #1;
        check("t1_ptr3_gnt", gnt_a, 32'h8);
        va = 4'b0000;
        tick(); #1;
        check("t1_withdraw_gnt", gnt_a, 32'h0);

        // Back-pressure on requester 1.
        va = 4'b0010; ora = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_bp_sel", sel_a, 32'h1);
            check("t3_bp_gnt", gnt_a, 32'h2);
            check("t3_bp_rdy", rdy_a, 32'h0);
            check("t3_bp_ov", ov_a, 32'h1);
            tick();
        end
        ora = 1'b1; #1;
        check("t3_accept_rdy", rdy_a, 32'h2);
        check("t3_accept_data", od_a, d1);
        tick();
        check("t3_still_gnt", gnt_a, 32'h2);
        va = 4'b0000; #1;
        check("t3_withdraw_ov", ov_a, 32'h0);
        tick(); #1;
        check("t3_release_gnt", gnt_a, 32'h0);

        // Requester 3 withdraws after two transfers; pending 0 wins next.
        va = 4'b1001;
        tick(); #1;
        check("t4_gnt3", gnt_a, 32'h8);
        check("t4_data3", od_a, d3);
        tick();
        tick();
        va = 4'b0001; #1;
        check("t4_drop_ov", ov_a, 32'h0);
        tick(); #1;
        check("t4_idle_gnt", gnt_a, 32'h0);
        tick(); #1;
        check("t4_next0_gnt", gnt_a, 32'h1);
        check("t4_next0_data", od_a, d0);
        va = 4'b0000;
        tick();

        // Reset while granted at beat 2.
        va = 4'b0100;
        tick(); tick(); tick();
        rst_n = 1'b0; va = 4'b1111; #1;
        check("t5_inflight_ov", ov_a, 32'h1);
        tick(); #1;
        check("t5_rst_gnt", gnt_a, 32'h0);
        check("t5_rst_sel", sel_a, 32'h0);
        check("t5_rst_ov", ov_a, 32'h0);
        rst_n = 1'b1;
        tick(); #1;
        check("t5_rearb_gnt", gnt_a, 32'h1);
        va = 4'b0000;
        tick();

        // MAX_BURST=1 rotation with all four requesting.
        vb = 4'b1111; ob = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            check("t2_gnt", gnt_b, 32'h1 << (i % 4));
            check("t2_data", od_b, dat[i % 4]);
            tick(); #1;
            check("t2_bubble", gnt_b, 32'h0);
        end
        vb = 4'b0000;

`ifdef MUX_ARB_STATS_EN
        #1;
        check("st_reset_cnt", cnt_c, 32'h0);
        vc = 4'b0100; oc = 1'b1;
        tick();
        tick(); tick(); tick(); tick(); tick(); #1;
        check("st_sat_cnt2", cnt_c[5:4], 32'h3);
        check("st_cnt0", cnt_c[1:0], 32'h0);
        clrc = 1'b1; #1;
        check("st_clr_xfer_ov", ov_c, 32'h1);
        tick(); #1;
        check("st_clr_cnt2", cnt_c[5:4], 32'h0);
        clrc = 1'b0; vc = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
